region_stream_reader: RTL and testbench
=======================================

Name: region_stream_reader

Overview:
- Downstream consumer of one replicated region read channel. Turns a start command into a stream of region reads.
- Each command reads either a BRAM address range or a number of FIFO entries.
- Data goes out on a valid/ready stream with last-beat marking, so the compute pipelines can take region data without tracking read latency themselves.
- One instance per read channel.

Parameters:
- WIDTH, 8, data width in bits of the region word and of the output stream.
- LOG2_DEPTH, 5, log2 of region depth; sets the address width and the count width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  command strobe; accepted only when busy=0
- src_sel  in  1  0 = BRAM region, 1 = FIFO region
- base_addr  in  LOG2_DEPTH  first BRAM address (ignored for FIFO)
- count  in  LOG2_DEPTH+1  number of words to read, 0..2^LOG2_DEPTH
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when the command completes
- re  out  1  read enable to region channel
- raddr  out  LOG2_DEPTH  BRAM read address
- rfifobram  out  2  01 = BRAM, 10 = FIFO; held stable for the whole command
- rvalid  in  1  read data valid from region
- rdata  in  WIDTH  read data from region
- empty  in  1  region FIFO empty
- out_valid  out  1  stream valid
- out_data  out  WIDTH  stream data
- out_last  out  1  final word of the command
- out_ready  in  1  downstream accept

Behaviour:
- Reset values: busy=0, done=0, re=0, raddr=0, rfifobram=00, out_valid=0, out_last=0, out_data=0. Internal counters are 0 and the output buffer is empty.
- Read latency: the region returns rvalid/rdata exactly 1 cycle after re=1. At most 1 read is in flight at a time.
- Output buffer: 2-entry FIFO holding {data, last}. out_valid = buffer non-empty. A word transfers when out_valid && out_ready.
- Credit rule: re may be asserted only when (buffer occupancy + in-flight reads − pops this cycle) < 2. Data is never dropped, whatever the out_ready pattern.
- FSM has three states: IDLE, ISSUE, DRAIN.
  - IDLE: on start, latch src_sel, base_addr and count, and set rfifobram.
    - count=0: go straight to DRAIN. No reads are issued; done pulses on the next cycle.
    - Otherwise go to ISSUE; busy=1 from the cycle after start.
  - ISSUE: assert re when credit is available and, for FIFO source, empty=0.
    - Each issued read increments raddr (BRAM, wraps modulo 2^LOG2_DEPTH) and decrements the remaining-issue counter.
    - When the last read is issued, go to DRAIN.
  - DRAIN: wait until every in-flight read has returned and the buffer is empty with the last word accepted. Then pulse done for 1 cycle, drop busy, go to IDLE.
- out_last is set on the word whose return index equals count−1.
- rvalid arriving when no read is in flight is ignored.
- start while busy=1 is ignored. A start in the same cycle as done is also ignored; a new command is accepted no earlier than the cycle after done.
- BRAM wrap example: base_addr=30, count=4, LOG2_DEPTH=5 gives reads at 30, 31, 0, 1.
- FIFO underflow: while empty=1, re stays 0 and the FSM stalls in ISSUE indefinitely. There is no timeout.
- Reset asserted mid-command: everything returns to reset values immediately. The buffer is flushed and late-returning rvalid is discarded.
- Throughput: with out_ready held at 1, one word per cycle sustained after the first-word latency of 2 cycles from start.

Optional Feature:
- Macro: REGION_STREAM_READER_PERF_EN.
- When defined:
  - Adds output stall_cycles, 32 bits wide, reset 0.
  - It increments on every cycle with out_valid=1 && out_ready=0, and saturates at all-ones.
  - It clears when a new command is accepted.
- When undefined: the port and counter do not exist, and the rest of the behaviour is identical.

Test Plan:
- BRAM preloaded with addr i = i; start src_sel=0, base=4, count=8, out_ready=1 -> out_data 4..11 on consecutive cycles; out_last with 11; done 1 cycle after that accept.
- base=30, count=4 -> raddr sequence 30, 31, 0, 1; data matches those addresses.
- out_ready toggling 1,0,0,1 repeating during a count=16 BRAM read -> all 16 words in order, no duplicates or loss; re never asserted with 2 words buffered or pending.
- FIFO source, count=3, empty=1 for 5 cycles then FIFO fills with A, B, C -> re stays 0 while empty; output A, B, C with out_last on C.
- count=0 -> no re ever asserted; done pulses 1 cycle after start. start asserted while busy -> ignored, with no change to raddr or count.
- reset pulsed after 3 of 10 words -> all outputs back to 0 immediately; a new 2-word command after reset outputs only its own 2 words.

Source files
------------

// File: rtl/region_stream_reader.sv
// -----------------------------------------------------------------------------
// region_stream_reader
//
// Purpose:
//   Consumer of one region read channel. A start command reads either a BRAM
//   address range (src_sel=0) or a number of FIFO entries (src_sel=1). The
//   returned words go out on a valid/ready stream with the final word of the
//   command marked by out_last. The region has a fixed one-cycle read latency.
//   A two-entry output buffer absorbs it, and a credit check on every read
//   keeps any out_ready pattern from losing data.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               command strobe (taken only while idle)
//   src_sel             0 = BRAM region, 1 = FIFO region
//   base_addr           first BRAM address (ignored for FIFO)
//   count               words to read, 0 .. 2**LOG2_DEPTH
//   busy, done          command in progress / one-cycle completion pulse
//   re, raddr           region read enable and BRAM read address
//   rfifobram           01 = BRAM, 10 = FIFO, held for the whole command
//   rvalid, rdata       region read return (one cycle after re)
//   empty               region FIFO empty
//   out_valid/out_data/out_last/out_ready   output stream
//   stall_cycles        (only with REGION_STREAM_READER_PERF_EN) saturating
//                       count of cycles with out_valid=1 and out_ready=0
//
// Optional feature macro: REGION_STREAM_READER_PERF_EN
// -----------------------------------------------------------------------------
module region_stream_reader #(
   parameter int WIDTH      = 8,
   parameter int LOG2_DEPTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  src_sel,
   input  logic [LOG2_DEPTH-1:0] base_addr,
   input  logic [LOG2_DEPTH:0]   count,
   output logic                  busy,
   output logic                  done,
   output logic                  re,
   output logic [LOG2_DEPTH-1:0] raddr,
   output logic [1:0]            rfifobram,
   input  logic                  rvalid,
   input  logic [WIDTH-1:0]      rdata,
   input  logic                  empty,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_last,
   input  logic                  out_ready
`ifdef REGION_STREAM_READER_PERF_EN
   ,
   output logic [31:0]           stall_cycles
`endif
);

   localparam int CW = LOG2_DEPTH + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t                state_reg, state_next;
   logic                  src_reg;
   logic [LOG2_DEPTH-1:0] raddr_reg;
   logic [CW-1:0]         count_reg;
   logic [CW-1:0]         issue_left_reg;
   logic [CW-1:0]         ret_idx_reg;
   logic                  inflight_reg;
   logic                  last_acc_reg;
   logic [1:0]            rfifobram_reg;

   // Output buffer: two entries addressed by one-bit pointers
   logic [WIDTH-1:0]      buf_data_reg [2];
   logic                  buf_last_reg [2];
   logic                  wr_ptr_reg, rd_ptr_reg;
   logic [1:0]            occ_reg;

   logic                  accept_cmd;
   logic                  push, pop, push_last;
   logic [2:0]            load;
   logic                  can_issue;
   logic                  drain_done;

   assign accept_cmd = start && (state_reg == IDLE);

   // A return is only taken when a read is actually outstanding; stray
   // rvalid pulses (e.g. a read launched before a reset) are dropped.
   assign push      = rvalid && inflight_reg;
   assign pop       = (occ_reg != 2'd0) && out_ready;
   assign push_last = (ret_idx_reg == (count_reg - CW'(1)));

   // Words already committed to the buffer: those stored plus the read that
   // is in flight, minus the one leaving this cycle. A new read is only
   // launched if that leaves room for its return.
   assign load = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop};

   // At most one outstanding read: a new read may go out in the same cycle
   // the previous one returns.
   assign can_issue = (issue_left_reg != '0) && (load < 3'd2) &&
                      (!inflight_reg || rvalid) && (!src_reg || !empty);

   // last_acc_reg is preset for zero-length commands so DRAIN finishes at once
   assign drain_done = !inflight_reg && (occ_reg == 2'd0) && last_acc_reg;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = (count == '0) ? DRAIN : ISSUE;
            end
         end
         ISSUE: begin
            if (re && (issue_left_reg == CW'(1))) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_done) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      re   = 1'b0;
      case (state_reg)
         ISSUE: begin
            busy = 1'b1;
            re   = can_issue;
         end
         DRAIN: begin
            busy = 1'b1;
            done = drain_done;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src_reg        <= 1'b0;
         raddr_reg      <= '0;
         count_reg      <= '0;
         issue_left_reg <= '0;
         ret_idx_reg    <= '0;
         inflight_reg   <= 1'b0;
         last_acc_reg   <= 1'b0;
         rfifobram_reg  <= 2'b00;
         wr_ptr_reg     <= 1'b0;
         rd_ptr_reg     <= 1'b0;
         occ_reg        <= 2'd0;
      end else begin
         if (accept_cmd) begin
            src_reg        <= src_sel;
            raddr_reg      <= base_addr;
            count_reg      <= count;
            issue_left_reg <= count;
            ret_idx_reg    <= '0;
            last_acc_reg   <= (count == '0);
            rfifobram_reg  <= src_sel ? 2'b10 : 2'b01;
         end else begin
            if (re) begin
               issue_left_reg <= issue_left_reg - CW'(1);
               if (!src_reg) begin
                  raddr_reg <= raddr_reg + 1'b1;   // wraps at region depth
               end
            end
            if (push) begin
               ret_idx_reg <= ret_idx_reg + CW'(1);
            end
            if (pop && buf_last_reg[rd_ptr_reg]) begin
               last_acc_reg <= 1'b1;
            end
         end
         inflight_reg <= re || (inflight_reg && !rvalid);
         if (push) begin
            wr_ptr_reg <= ~wr_ptr_reg;
         end
         if (pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         occ_reg <= occ_reg + {1'b0, push} - {1'b0, pop};
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_buf
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               buf_data_reg[gi] <= '0;
               buf_last_reg[gi] <= 1'b0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
               buf_data_reg[gi] <= rdata;
               buf_last_reg[gi] <= push_last;
            end
         end
      end
   endgenerate

   assign raddr     = raddr_reg;
   assign rfifobram = rfifobram_reg;
   assign out_valid = (occ_reg != 2'd0);
   assign out_data  = out_valid ? buf_data_reg[rd_ptr_reg] : '0;
   assign out_last  = out_valid ? buf_last_reg[rd_ptr_reg] : 1'b0;

`ifdef REGION_STREAM_READER_PERF_EN
   logic [31:0] stall_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_reg <= '0;
      end else if (accept_cmd) begin
         stall_reg <= '0;
      end else if (out_valid && !out_ready && (stall_reg != '1)) begin
         stall_reg <= stall_reg + 32'd1;
      end
   end

   assign stall_cycles = stall_reg;
`endif

endmodule

// File: tb/tb_region_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_region_stream_reader
//
// Directed bench for region_stream_reader. A behavioural region answers every
// read one cycle later (BRAM word at address i holds i; FIFO fed from a queue).
// A monitor logs accepted words, issued addresses and done pulses, and keeps
// its own count of reads not yet accepted downstream for the credit check.
// -----------------------------------------------------------------------------
module tb_region_stream_reader;

   localparam int WIDTH      = 8;
   localparam int LOG2_DEPTH = 5;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic             src_sel = 1'b0;
   logic [4:0]       base_addr = '0;
   logic [5:0]       count = '0;
   logic             busy, done, re;
   logic [4:0]       raddr;
   logic [1:0]       rfifobram;
   logic             rvalid = 1'b0;
   logic [7:0]       rdata = '0;
   logic             empty = 1'b1;
   logic             out_valid;
   logic [7:0]       out_data;
   logic             out_last;
   logic             out_ready = 1'b1;
`ifdef REGION_STREAM_READER_PERF_EN
   logic [31:0]      stall_cycles;
`endif

   region_stream_reader #(.WIDTH(WIDTH), .LOG2_DEPTH(LOG2_DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start), .src_sel(src_sel),
      .base_addr(base_addr), .count(count), .busy(busy), .done(done),
      .re(re), .raddr(raddr), .rfifobram(rfifobram), .rvalid(rvalid),
      .rdata(rdata), .empty(empty), .out_valid(out_valid),
      .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
`ifdef REGION_STREAM_READER_PERF_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always @(posedge clk) cyc++;

   // ------------------------------------------------------------ region model
   logic [7:0] bram [32];
   logic [7:0] fifo_q [$];
   logic       cap_re = 1'b0;
   logic [7:0] cap_data = '0;

   always @(negedge clk) begin
      cap_re   = re && !reset;
      cap_data = 8'h00;
      if (cap_re) begin
         if (rfifobram == 2'b10) begin
            if (fifo_q.size() > 0) cap_data = fifo_q.pop_front();
         end else begin
            cap_data = bram[raddr];
         end
      end
   end

   always @(posedge clk) begin
      #1;
      rvalid = cap_re;
      rdata  = cap_data;
      empty  = (fifo_q.size() == 0);
   end

   // ------------------------------------------------------------ monitor
   int         pend = 0;
   int         re_cnt = 0, done_cnt = 0, done_cyc = 0;
   int         credit_viol = 0, empty_viol = 0;
   logic       pop_now;
   logic [7:0] acc_data [$];
   logic       acc_last [$];
   int         acc_cyc [$];
   logic [4:0] raddr_log [$];

   always @(negedge clk) begin
      if (reset) begin
         pend = 0;
      end else begin
         pop_now = out_valid && out_ready;
         if (re && ((pend - (pop_now ? 1 : 0)) >= 2)) credit_viol++;
         if (re && (rfifobram == 2'b10) && empty) empty_viol++;
         if (re) begin
            raddr_log.push_back(raddr);
            re_cnt++;
         end
         if (pop_now) begin
            acc_data.push_back(out_data);
            acc_last.push_back(out_last);
            acc_cyc.push_back(cyc);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         pend = pend + (re ? 1 : 0) - (pop_now ? 1 : 0);
      end
   end

   // ------------------------------------------------------------ helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      re_cnt = 0; done_cnt = 0; credit_viol = 0; empty_viol = 0;
      acc_data.delete(); acc_last.delete(); acc_cyc.delete(); raddr_log.delete();
   endtask

   task automatic start_cmd(input logic s, input logic [4:0] b, input logic [5:0] n,
                            output int s_cyc);
      src_sel = s; base_addr = b; count = n; start = 1'b1;
      s_cyc = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (done_cnt == 0) begin
         errors++;
         $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
      end
   endtask

   // ------------------------------------------------------------ tests
   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0)      begin errors++; $display("FAIL rst_done: got %b want 0", done); end
      checks++; if (re !== 1'b0)        begin errors++; $display("FAIL rst_re: got %b want 0", re); end
      checks++; if (raddr !== 5'd0)     begin errors++; $display("FAIL rst_raddr: got %0d want 0", raddr); end
      checks++; if (rfifobram !== 2'b00) begin errors++; $display("FAIL rst_rfifobram: got %b want 00", rfifobram); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL rst_out_last: got %b want 0", out_last); end
      checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %0h want 0", out_data); end
      reset = 1'b0;
      tick();
      $display("reset: outputs checked");
   endtask

   task automatic test_bram_basic();
      int s;
      clear_logs();
      out_ready = 1'b1;
      start_cmd(1'b0, 5'd4, 6'd8, s);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
      checks++; if (rfifobram !== 2'b01) begin errors++; $display("FAIL basic_rfifobram: got %b want 01", rfifobram); end
      wait_done(60, "basic");
      checks++; if (acc_data.size() !== 8) begin errors++; $display("FAIL basic_words: got %0d want 8", acc_data.size()); end
      for (int i = 0; i < 8 && i < acc_data.size(); i++) begin
         checks++; if (acc_data[i] !== 8'(4 + i)) begin errors++; $display("FAIL basic_data[%0d]: got %0d want %0d", i, acc_data[i], 4 + i); end
         checks++; if (acc_last[i] !== (i == 7)) begin errors++; $display("FAIL basic_last[%0d]: got %b want %b", i, acc_last[i], i == 7); end
         checks++; if (acc_cyc[i] !== s + 3 + i) begin errors++; $display("FAIL basic_cycle[%0d]: got %0d want %0d", i, acc_cyc[i], s + 3 + i); end
      end
      if (acc_cyc.size() == 8) begin
         checks++; if (done_cyc !== acc_cyc[7] + 1) begin errors++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, acc_cyc[7] + 1); end
      end
      checks++; if (re_cnt !== 8) begin errors++; $display("FAIL basic_reads: got %0d want 8", re_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", busy); end
      $display("bram base=4 count=8: %0d words, done at cycle %0d", acc_data.size(), done_cyc);
   endtask

   task automatic test_bram_wrap();
      int s;
      logic [4:0] exp_a [4];
      exp_a[0] = 5'd30; exp_a[1] = 5'd31; exp_a[2] = 5'd0; exp_a[3] = 5'd1;
      clear_logs();
      out_ready = 1'b1;
      start_cmd(1'b0, 5'd30, 6'd4, s);
      wait_done(40, "wrap");
      checks++; if (raddr_log.size() !== 4) begin errors++; $display("FAIL wrap_reads: got %0d want 4", raddr_log.size()); end
      checks++; if (acc_data.size() !== 4) begin errors++; $display("FAIL wrap_words: got %0d want 4", acc_data.size()); end
      for (int i = 0; i < 4; i++) begin
         if (i < raddr_log.size()) begin
            checks++; if (raddr_log[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_raddr[%0d]: got %0d want %0d", i, raddr_log[i], exp_a[i]); end
         end
         if (i < acc_data.size()) begin
            checks++; if (acc_data[i] !== {3'b000, exp_a[i]}) begin errors++; $display("FAIL wrap_data[%0d]: got %0d want %0d", i, acc_data[i], exp_a[i]); end
         end
      end
      $display("bram base=30 count=4: %0d words", acc_data.size());
   endtask

   task automatic test_backpressure();
      int s;
      int k = 0;
      logic [3:0] pat = 4'b1001;   // out_ready per cycle: 1,0,0,1
      clear_logs();
      out_ready = 1'b1;
      start_cmd(1'b0, 5'd0, 6'd16, s);
      while (done_cnt == 0 && k < 300) begin
         out_ready = pat[k % 4];
         tick();
         k++;
      end
      out_ready = 1'b1;
      checks++; if (done_cnt == 0) begin errors++; $display("FAIL bp_timeout: done not seen within 300 cycles"); end
      checks++; if (acc_data.size() !== 16) begin errors++; $display("FAIL bp_words: got %0d want 16", acc_data.size()); end
      for (int i = 0; i < 16 && i < acc_data.size(); i++) begin
         checks++; if (acc_data[i] !== 8'(i)) begin errors++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, acc_data[i], i); end
         checks++; if (acc_last[i] !== (i == 15)) begin errors++; $display("FAIL bp_last[%0d]: got %b want %b", i, acc_last[i], i == 15); end
      end
      checks++; if (credit_viol !== 0) begin errors++; $display("FAIL bp_credit: got %0d violations want 0", credit_viol); end
      checks++; if (re_cnt !== 16) begin errors++; $display("FAIL bp_reads: got %0d want 16", re_cnt); end
      tick();
      $display("bram count=16 with backpressure: %0d words", acc_data.size());
   endtask

   task automatic test_fifo();
      int s;
      clear_logs();
      out_ready = 1'b1;
      start_cmd(1'b1, 5'd0, 6'd3, s);
      repeat (5) tick();
      checks++; if (re_cnt !== 0) begin errors++; $display("FAIL fifo_stall_reads: got %0d want 0", re_cnt); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fifo_stall_busy: got %b want 1", busy); end
      checks++; if (rfifobram !== 2'b10) begin errors++; $display("FAIL fifo_rfifobram: got %b want 10", rfifobram); end
      fifo_q.push_back(8'hA1); fifo_q.push_back(8'hB2); fifo_q.push_back(8'hC3);
      wait_done(40, "fifo");
      checks++; if (acc_data.size() !== 3) begin errors++; $display("FAIL fifo_words: got %0d want 3", acc_data.size()); end
      if (acc_data.size() == 3) begin
         checks++; if (acc_data[0] !== 8'hA1) begin errors++; $display("FAIL fifo_data0: got %0h want a1", acc_data[0]); end
         checks++; if (acc_data[1] !== 8'hB2) begin errors++; $display("FAIL fifo_data1: got %0h want b2", acc_data[1]); end
         checks++; if (acc_data[2] !== 8'hC3) begin errors++; $display("FAIL fifo_data2: got %0h want c3", acc_data[2]); end
         checks++; if ({acc_last[0], acc_last[1], acc_last[2]} !== 3'b001) begin errors++; $display("FAIL fifo_last: got %b%b%b want 001", acc_last[0], acc_last[1], acc_last[2]); end
      end
      checks++; if (empty_viol !== 0) begin errors++; $display("FAIL fifo_read_when_empty: got %0d want 0", empty_viol); end
      $display("fifo count=3: %0d words", acc_data.size());
   endtask

   task automatic test_zero_count();
      int s;
      clear_logs();
      // start held for two cycles: the second cycle coincides with done
      src_sel = 1'b0; base_addr = 5'd9; count = 6'd0; start = 1'b1;
      s = cyc;
      tick(); tick();
      start = 1'b0;
      repeat (4) tick();
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
      checks++; if (done_cyc !== s + 1) begin errors++; $display("FAIL zero_done_cycle: got %0d want %0d", done_cyc, s + 1); end
      checks++; if (re_cnt !== 0) begin errors++; $display("FAIL zero_reads: got %0d want 0", re_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", busy); end
      $display("count=0: done pulses=%0d", done_cnt);
   endtask

   task automatic test_start_while_busy();
      int s;
      clear_logs();
      out_ready = 1'b0;
      start_cmd(1'b0, 5'd4, 6'd8, s);
      tick(); tick();
      src_sel = 1'b1; base_addr = 5'd20; count = 6'd2; start = 1'b1;
      tick(); tick();
      start = 1'b0;
      checks++; if (rfifobram !== 2'b01) begin errors++; $display("FAIL busy_rfifobram: got %b want 01", rfifobram); end
      out_ready = 1'b1;
      wait_done(60, "busy_start");
      checks++; if (acc_data.size() !== 8) begin errors++; $display("FAIL busy_words: got %0d want 8", acc_data.size()); end
      checks++; if (raddr_log.size() !== 8) begin errors++; $display("FAIL busy_reads: got %0d want 8", raddr_log.size()); end
      for (int i = 0; i < 8; i++) begin
         if (i < acc_data.size()) begin
            checks++; if (acc_data[i] !== 8'(4 + i)) begin errors++; $display("FAIL busy_data[%0d]: got %0d want %0d", i, acc_data[i], 4 + i); end
         end
         if (i < raddr_log.size()) begin
            checks++; if (raddr_log[i] !== 5'(4 + i)) begin errors++; $display("FAIL busy_raddr[%0d]: got %0d want %0d", i, raddr_log[i], 4 + i); end
         end
      end
      checks++; if (credit_viol !== 0) begin errors++; $display("FAIL busy_credit: got %0d violations want 0", credit_viol); end
      $display("start while busy: %0d words of original command", acc_data.size());
   endtask

   task automatic test_reset_mid();
      int s;
      int n = 0;
      clear_logs();
      out_ready = 1'b1;
      start_cmd(1'b0, 5'd0, 6'd10, s);
      while (acc_data.size() < 3 && n < 40) begin
         tick();
         n++;
      end
      checks++; if (acc_data.size() !== 3) begin errors++; $display("FAIL mid_pre_words: got %0d want 3", acc_data.size()); end
      reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
      checks++; if (re !== 1'b0)        begin errors++; $display("FAIL mid_re: got %b want 0", re); end
      checks++; if (raddr !== 5'd0)     begin errors++; $display("FAIL mid_raddr: got %0d want 0", raddr); end
      checks++; if (rfifobram !== 2'b00) begin errors++; $display("FAIL mid_rfifobram: got %b want 00", rfifobram); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
      checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL mid_out_data: got %0h want 0", out_data); end
      checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL mid_out_last: got %b want 0", out_last); end
      tick();
      reset = 1'b0;
      clear_logs();
      tick();
      start_cmd(1'b0, 5'd20, 6'd2, s);
      wait_done(40, "post_reset");
      checks++; if (acc_data.size() !== 2) begin errors++; $display("FAIL post_words: got %0d want 2", acc_data.size()); end
      if (acc_data.size() == 2) begin
         checks++; if (acc_data[0] !== 8'd20) begin errors++; $display("FAIL post_data0: got %0d want 20", acc_data[0]); end
         checks++; if (acc_data[1] !== 8'd21) begin errors++; $display("FAIL post_data1: got %0d want 21", acc_data[1]); end
         checks++; if ({acc_last[0], acc_last[1]} !== 2'b01) begin errors++; $display("FAIL post_last: got %b%b want 01", acc_last[0], acc_last[1]); end
      end
      $display("reset mid-command then count=2: %0d words", acc_data.size());
   endtask

   initial begin
      for (int i = 0; i < 32; i++) bram[i] = 8'(i);
      test_reset();
      test_bram_basic();
      test_bram_wrap();
      test_backpressure();
      test_fifo();
      test_zero_count();
      test_start_while_busy();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
